// File: rtl/m_pwr_pkg.sv
// Shared types and voltage constants for the power-sequencer models.
// Voltages are in 10 mV units throughout.
package m_pwr_pkg;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_RAMP  = 3'd1,
    S_ON    = 3'd2,
    S_FALL  = 3'd3,
    S_FAULT = 3'd4
  } t_rail;

  localparam logic [15:0] V_3V3     = 16'd330;
  localparam logic [15:0] V_CPU_MIN = 16'd300;

endpackage

// File: rtl/m_tick_div.sv
// Prescaler producing a one-cycle tick every DIV cycles while run is high.
// clr restarts the count so the first tick lands a full DIV cycles later.
module m_tick_div #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/m_pwr_rail.sv
// Soft-start regulator model: ramps vout to V_TARGET on enable, raises pgood
// after a settle delay, ramps down on disable, and collapses on fault.
module m_pwr_rail
  import m_pwr_pkg::*;
#(
  parameter int unsigned V_TARGET  = 330,
  parameter int unsigned RAMP_STEP = 5,
  parameter int unsigned FALL_STEP = 10,
  parameter int unsigned TICK_DIV  = 100,
  parameter int unsigned PG_DLY    = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        fault,
  output logic [15:0] vout,
  output logic        pgood,
  output logic [2:0]  state
);

  localparam int unsigned   SW          = (PG_DLY > 1) ? $clog2(PG_DLY) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(PG_DLY - 1);
  localparam logic [15:0]   VT16        = 16'(V_TARGET);
  localparam logic [16:0]   VT17        = 17'(V_TARGET);
  localparam logic [16:0]   RS17        = 17'(RAMP_STEP);
  localparam logic [16:0]   FS17        = 17'(FALL_STEP);

  t_rail         st_q;
  t_rail         st_d;
  logic [15:0]   vout_d;
  logic [SW-1:0] settle_cnt;
  logic [16:0]   ramp_sum;
  logic          tick;
  logic          tick_run;
  logic          tick_clr;

  // 17-bit sum so the clamp against V_TARGET sees the true value near 16'hFFFF.
  assign ramp_sum = {1'b0, vout} + RS17;
  assign tick_run = (st_q == S_RAMP) || (st_q == S_FALL);
  assign tick_clr = (st_d != st_q);
  assign state    = st_q;

  m_tick_div #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .run   (tick_run),
    .tick  (tick)
  );

  // NOTE: every output of this block gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    st_d   = st_q;
    vout_d = vout;
    if (fault) begin
      st_d   = S_FAULT;
      vout_d = '0;
    end else begin
      case (st_q)
        S_OFF: begin
          if (en) st_d = S_RAMP;
        end
        S_RAMP: begin
          if (!en)               st_d   = S_FALL;
          else if (vout == VT16) st_d   = S_ON;
          else if (tick)         vout_d = (ramp_sum > VT17) ? VT16 : ramp_sum[15:0];
        end
        S_ON: begin
          vout_d = VT16;
          if (!en) st_d = S_FALL;
        end
        S_FALL: begin
          if (en)              st_d   = S_RAMP;
          else if (vout == '0) st_d   = S_OFF;
          else if (tick)       vout_d = ({1'b0, vout} > FS17) ? vout - FS17[15:0] : '0;
        end
        S_FAULT: begin
          if (!en) st_d = S_OFF;
        end
        default: begin
          st_d   = S_OFF;
          vout_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= S_OFF;
      vout       <= '0;
      pgood      <= 1'b0;
      settle_cnt <= '0;
    end else begin
      st_q <= st_d;
      vout <= vout_d;
      // Settle count only advances while staying in S_ON; any exit or entry edge clears it.
      if (st_q == S_ON && st_d == S_ON) begin
        if (settle_cnt == SETTLE_LAST) pgood      <= 1'b1;
        else                           settle_cnt <= settle_cnt + 1'b1;
      end else begin
        settle_cnt <= '0;
        pgood      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m_pwr_rail.sv
// Directed and randomized check of m_pwr_rail against a cycle-age reference model.
module tb_m_pwr_rail;
  import m_pwr_pkg::*;

  localparam int VT = 330;
  localparam int RS = 5;
  localparam int FS = 10;
  localparam int TD = 10;
  localparam int PD = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        fault;
  logic [15:0] vout, vout2;
  logic        pgood, pgood2;
  logic [2:0]  state, state2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  t_rail m_st;
  int    m_v;
  int    m_age;
  bit    m_pg;

  always #5 clk = ~clk;

  m_pwr_rail #(
    .V_TARGET (VT), .RAMP_STEP (RS), .FALL_STEP (FS), .TICK_DIV (TD), .PG_DLY (PD)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .en (en), .fault (fault),
    .vout (vout), .pgood (pgood), .state (state)
  );

  m_pwr_rail #(
    .V_TARGET (333), .RAMP_STEP (RS), .FALL_STEP (FS), .TICK_DIV (TD), .PG_DLY (PD)
  ) u_dut2 (
    .clk (clk), .rst_n (rst_n), .en (en), .fault (fault),
    .vout (vout2), .pgood (pgood2), .state (state2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_st  = S_OFF;
    m_v   = 0;
    m_age = 0;
    m_pg  = 1'b0;
  endfunction

  // Tick timing follows from cycles spent in the current state.
  function automatic void model_edge(input bit en_s, input bit fault_s);
    t_rail nxt = m_st;
    int    nv  = m_v;
    bit    tk  = (m_st == S_RAMP || m_st == S_FALL) && (m_age % TD == TD - 1);
    if (fault_s) begin
      nxt = S_FAULT;
      nv  = 0;
    end else begin
      case (m_st)
        S_OFF:   if (en_s) nxt = S_RAMP;
        S_RAMP:  if (!en_s) nxt = S_FALL;
                 else if (m_v == VT) nxt = S_ON;
                 else if (tk) nv = (m_v + RS > VT) ? VT : m_v + RS;
        S_ON:    if (!en_s) nxt = S_FALL;
        S_FALL:  if (en_s) nxt = S_RAMP;
                 else if (m_v == 0) nxt = S_OFF;
                 else if (tk) nv = (m_v < FS) ? 0 : m_v - FS;
        S_FAULT: if (!en_s) nxt = S_OFF;
        default: nxt = S_OFF;
      endcase
    end
    m_age = (nxt == m_st) ? m_age + 1 : 0;
    m_st  = nxt;
    m_v   = nv;
    m_pg  = (m_st == S_ON) && (m_age >= PD);
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge(en, fault);
    cyc++;
    #1;
    check("vout",  32'(vout),  32'(m_v));
    check("state", 32'(state), 32'(m_st));
    check("pgood", 32'(pgood), 32'(m_pg));
  endtask

  task automatic run_to(input int base, input int off);
    while (cyc - base < off) cycle();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_vout",  32'(vout),  32'd0);
    check("rst_async_state", 32'(state), 32'(S_OFF));
    check("rst_async_pgood", 32'(pgood), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_vout", 32'(vout), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int e0, f0, r0, g0, lim;
    rst_n = 1'b0;
    en    = 1'b0;
    fault = 1'b0;
    model_reset();
    #12;
    check("reset_vout",   32'(vout),   32'd0);
    check("reset_state",  32'(state),  32'(S_OFF));
    check("reset_pgood",  32'(pgood),  32'd0);
    check("reset_vout2",  32'(vout2),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cycle();

    // Ramp to 330, non-multiple target 333 on the second instance, settle.
    en = 1'b1;
    e0 = cyc;
    run_to(e0, 1);   check("ramp_enter",   32'(state),  32'(S_RAMP));
    run_to(e0, 10);  check("ramp_pre1",    32'(vout),   32'd0);
    run_to(e0, 11);  check("ramp_first",   32'(vout),   32'd5);
    run_to(e0, 600); check("ramp_295",     32'(vout),   32'd295);
    run_to(e0, 601); check("ramp_300",     32'(vout),   32'd300);
    run_to(e0, 661); check("ramp_top",     32'(vout),   32'd330);
                     check("ramp_still",   32'(state),  32'(S_RAMP));
                     check("t333_at_330",  32'(vout2),  32'd330);
    run_to(e0, 662); check("on_enter",     32'(state),  32'(S_ON));
    run_to(e0, 671); check("t333_clamp",   32'(vout2),  32'd333);
    run_to(e0, 672); check("t333_on",      32'(state2), 32'(S_ON));
    run_to(e0, 680); check("t333_hold",    32'(vout2),  32'd333);
    run_to(e0, 681); check("pg_early",     32'(pgood),  32'd0);
    run_to(e0, 682); check("pg_rise",      32'(pgood),  32'd1);

    // Fall from S_ON.
    run_to(e0, 700);
    en = 1'b0;
    f0 = cyc;
    run_to(f0, 1);   check("fall_pg",      32'(pgood),  32'd0);
                     check("fall_enter",   32'(state),  32'(S_FALL));
    run_to(f0, 11);  check("fall_first",   32'(vout),   32'd320);
    run_to(f0, 330); check("fall_10",      32'(vout),   32'd10);
    run_to(f0, 331); check("fall_zero",    32'(vout),   32'd0);
    run_to(f0, 332); check("fall_off",     32'(state),  32'(S_OFF));

    // Re-enable mid-fall resumes from the current voltage.
    en = 1'b1;
    e0 = cyc;
    run_to(e0, 201); check("re_100",       32'(vout),   32'd100);
    en = 1'b0;
    f0 = cyc;
    run_to(f0, 21);  check("re_80",        32'(vout),   32'd80);
    en = 1'b1;
    r0 = cyc;
    run_to(r0, 1);   check("re_resume_st", 32'(state),  32'(S_RAMP));
                     check("re_resume_v",  32'(vout),   32'd80);
    run_to(r0, 11);  check("re_85",        32'(vout),   32'd85);
    run_to(r0, 500); check("re_325",       32'(vout),   32'd325);
    run_to(r0, 501); check("re_330",       32'(vout),   32'd330);

    // Fault in S_ON latches until en and fault are both low.
    run_to(r0, 540); check("pre_fault_pg", 32'(pgood),  32'd1);
    fault = 1'b1;
    g0 = cyc;
    run_to(g0, 1);   check("fault_vout",   32'(vout),   32'd0);
                     check("fault_pg",     32'(pgood),  32'd0);
                     check("fault_state",  32'(state),  32'(S_FAULT));
    fault = 1'b0;
    run_to(g0, 6);   check("fault_latch",  32'(state),  32'(S_FAULT));
    en = 1'b0;
    run_to(g0, 7);   check("fault_exit",   32'(state),  32'(S_OFF));

    // Asynchronous reset mid-ramp, then restart from zero.
    en = 1'b1;
    e0 = cyc;
    run_to(e0, 301); check("pre_rst_150",  32'(vout),   32'd150);
    async_reset();
    e0 = cyc;
    run_to(e0, 1);   check("rst_restart",  32'(state),  32'(S_RAMP));
    run_to(e0, 11);  check("rst_first",    32'(vout),   32'd5);

    // Randomized enable/fault/reset traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      lim = (i < 2500) ? 59 : 799;
      if ($urandom_range(lim) == 0) en = ~en;
      if (fault) begin
        if ($urandom_range(3) == 0) fault = 1'b0;
      end else if ($urandom_range(499) == 0) begin
        fault = 1'b1;
      end
      if ($urandom_range(1499) == 0) async_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
